// File: rtl/alu_xbar_tile.sv
// CGRA compute tile: 4x4 input crossbar into a registered 16-op ALU with
// accumulator feedback, 2:1 output mux and a 13-bit serial configuration chain.
module alu_xbar_tile #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             config_en,
    input  logic             config_in,
    output logic             config_out,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1
);

    localparam int unsigned CFG_W = 13;
    localparam int unsigned SH_W  = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_AND  = 4'd3,
        OP_OR   = 4'd4,  OP_XOR  = 4'd5,  OP_SHL  = 4'd6,  OP_LSHR = 4'd7,
        OP_ASHR = 4'd8,  OP_EQ   = 4'd9,  OP_LTS  = 4'd10, OP_LTU  = 4'd11,
        OP_PA   = 4'd12, OP_PB   = 4'd13, OP_MINS = 4'd14, OP_NOTA = 4'd15
    } op_e;

    logic [CFG_W-1:0] r_cfg;
    logic [WIDTH-1:0] r_alu_q;

    op_e              w_opcode;
    logic             w_omux;
    logic [1:0]       w_s0, w_s1, w_s2, w_s3;
    logic [WIDTH-1:0] w_src [4];
    logic [WIDTH-1:0] w_a, w_b, w_xo2, w_xo3;
    logic [SH_W-1:0]  w_shamt;
    logic [WIDTH-1:0] w_alu_d;

    // Configuration fields are live straight off the chain; no shadow copy
    assign w_opcode = op_e'(r_cfg[12:9]);
    assign w_omux   = r_cfg[8];
    assign w_s0     = r_cfg[7:6];
    assign w_s1     = r_cfg[5:4];
    assign w_s2     = r_cfg[3:2];
    assign w_s3     = r_cfg[1:0];

    assign w_src[0] = in0;
    assign w_src[1] = in1;
    assign w_src[2] = r_alu_q;
    assign w_src[3] = '0;

    assign w_a     = w_src[w_s0];
    assign w_b     = w_src[w_s1];
    assign w_xo2   = w_src[w_s2];
    assign w_xo3   = w_src[w_s3];
    assign w_shamt = w_b[SH_W-1:0];

    always_comb begin
        w_alu_d = '0;
        case (w_opcode)
            OP_ADD:  w_alu_d = w_a + w_b;
            OP_SUB:  w_alu_d = w_a - w_b;
            OP_MUL:  w_alu_d = WIDTH'(w_a * w_b);
            OP_AND:  w_alu_d = w_a & w_b;
            OP_OR:   w_alu_d = w_a | w_b;
            OP_XOR:  w_alu_d = w_a ^ w_b;
            OP_SHL:  w_alu_d = w_a << w_shamt;
            OP_LSHR: w_alu_d = w_a >> w_shamt;
            OP_ASHR: w_alu_d = WIDTH'($signed(w_a) >>> w_shamt);
            OP_EQ:   w_alu_d = WIDTH'(w_a == w_b);
            OP_LTS:  w_alu_d = WIDTH'($signed(w_a) < $signed(w_b));
            OP_LTU:  w_alu_d = WIDTH'(w_a < w_b);
            OP_PA:   w_alu_d = w_a;
            OP_PB:   w_alu_d = w_b;
            OP_MINS: w_alu_d = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
            OP_NOTA: w_alu_d = ~w_a;
            default: w_alu_d = '0;
        endcase
    end

    // Chain shift and ALU update share an edge; the ALU sees the pre-edge cfg
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cfg   <= '0;
            r_alu_q <= '0;
        end else begin
            if (config_en) begin
                r_cfg <= {config_in, r_cfg[CFG_W-1:1]};
            end
            r_alu_q <= w_alu_d;
        end
    end

    assign config_out = r_cfg[0];
    assign out0       = w_omux ? w_xo2 : r_alu_q;
    assign out1       = w_xo3;

endmodule

// File: tb/tb_alu_xbar_tile.sv
// Scoreboard bench for alu_xbar_tile: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the live outputs.
module tb_alu_xbar_tile;

    localparam int unsigned W = 32;
    localparam int unsigned SIG_OUT0 = 0;
    localparam int unsigned SIG_OUT1 = 1;
    localparam int unsigned SIG_COUT = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         config_en = 1'b0;
    logic         config_in = 1'b0;
    logic         config_out;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] out0;
    logic [W-1:0] out1;

    typedef struct {
        int unsigned cyc;
        int unsigned sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_xbar_tile #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .in0        (in0),
        .in1        (in1),
        .out0       (out0),
        .out1       (out1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] act;
                case (sb[i].sig)
                    SIG_OUT0: act = out0;
                    SIG_OUT1: act = out1;
                    default:  act = {31'd0, config_out};
                endcase
                n_vec++;
                if (sb[i].cyc < cyc) begin
                    n_err++;
                    $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                             sb[i].name, sb[i].cyc, cyc);
                end else if (act !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             sb[i].name, act, sb[i].val, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int unsigned dly, input int unsigned sig,
                             input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [12:0] w);
        for (int i = 0; i < 13; i++) begin
            config_en = 1'b1;
            config_in = w[i];
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    // Sweep word: s0=in0, s1=in1, s2=s3=in0, omux 0
    function automatic logic [12:0] sweep_word(input logic [3:0] op);
        return {op, 9'h010};
    endfunction

    logic [31:0] sweep_exp [16];
    logic [12:0] chain_w;

    initial begin
        sweep_exp[0]  = 32'h80000005;
        sweep_exp[1]  = 32'h7FFFFFFD;
        sweep_exp[2]  = 32'h00000004;
        sweep_exp[3]  = 32'h00000000;
        sweep_exp[4]  = 32'h80000005;
        sweep_exp[5]  = 32'h80000005;
        sweep_exp[6]  = 32'h00000010;
        sweep_exp[7]  = 32'h08000000;
        sweep_exp[8]  = 32'hF8000000;
        sweep_exp[9]  = 32'h00000000;
        sweep_exp[10] = 32'h00000001;
        sweep_exp[11] = 32'h00000000;
        sweep_exp[12] = 32'h80000001;
        sweep_exp[13] = 32'h00000004;
        sweep_exp[14] = 32'h80000001;
        sweep_exp[15] = 32'h7FFFFFFE;

        // 1: reset state, then an all-zero load keeps cfg at zero
        in0 = 32'h11;
        tick();
        tick();
        expect_at(0, SIG_OUT0, 32'h0, "rst_out0");
        expect_at(0, SIG_OUT1, 32'h11, "rst_out1");
        expect_at(0, SIG_COUT, 32'h0, "rst_cfgout");
        reset = 1'b1;
        shift_word(13'h0);
        expect_at(0, SIG_COUT, 32'h0, "zero_load_cfgout");
        expect_at(0, SIG_OUT1, 32'h11, "zero_load_out1");
        expect_at(0, SIG_OUT0, 32'h22, "zero_load_add_in0_in0");

        // 2: ADD and SUB through in0/in1
        shift_word(13'h013);
        in0 = 32'd5;
        in1 = 32'd7;
        expect_at(0, SIG_OUT1, 32'h0, "xo3_zero");
        expect_at(1, SIG_OUT0, 32'd12, "add_5_7");
        tick();
        shift_word(13'h213);
        in0 = 32'd3;
        in1 = 32'd5;
        expect_at(1, SIG_OUT0, 32'hFFFFFFFE, "sub_3_5");
        tick();

        // 3: accumulator from a clean zero state, then mid-count reset
        in0 = '0;
        in1 = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        shift_word(13'h080);
        expect_at(0, SIG_OUT0, 32'h0, "acc_start");
        in0 = 32'd1;
        for (int k = 1; k <= 4; k++) begin
            expect_at(k, SIG_OUT0, 32'(k), $sformatf("acc_%0d", k));
        end
        repeat (4) tick();
        reset = 1'b0;
        expect_at(1, SIG_OUT0, 32'h0, "acc_reset");
        expect_at(1, SIG_COUT, 32'h0, "acc_reset_cfgout");
        tick();
        reset = 1'b1;

        // 4: opcode sweep with A=0x80000001, B=4
        in0 = 32'h80000001;
        in1 = 32'd4;
        for (int op = 0; op < 16; op++) begin
            shift_word(sweep_word(4'(op)));
            expect_at(1, SIG_OUT0, sweep_exp[op], $sformatf("op_%0d", op));
            tick();
        end

        // 5: combinational bypass to out0 via xo2
        shift_word(13'h104);
        in0 = 32'h12345678;
        in1 = 32'hDEADBEEF;
        expect_at(0, SIG_OUT0, 32'hDEADBEEF, "bypass_out0");
        expect_at(0, SIG_OUT1, 32'h12345678, "bypass_out1");
        tick();

        // 6: chain replay and hold
        chain_w = 13'h1ABC;
        shift_word(chain_w);
        for (int i = 0; i < 13; i++) begin
            expect_at(0, SIG_COUT, {31'd0, chain_w[i]}, $sformatf("replay_bit%0d", i));
            config_en = 1'b1;
            config_in = 1'b0;
            tick();
        end
        config_en = 1'b0;
        expect_at(0, SIG_COUT, 32'h0, "replay_drained");
        shift_word(13'h015);
        in1 = 32'h0000CAFE;
        config_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_at(0, SIG_COUT, 32'h1, $sformatf("hold_cfgout_%0d", i));
            expect_at(0, SIG_OUT1, 32'h0000CAFE, $sformatf("hold_out1_%0d", i));
            tick();
        end
        config_in = 1'b0;

        tick();
        tick();
        if (sb.size() != 0) begin
            n_vec += sb.size();
            n_err += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_xbar_tile.md
Name: alu_xbar_tile

Overview:
- Compute tile: a 4x4 input crossbar feeds a registered 16-op integer ALU, and a 2x1 output mux drives the tile output.
- The ALU result is fed back into the crossbar for accumulation.
- All routing and the opcode are held in a 13-bit serial configuration chain shifted on the data clock.
- Tiles daisy-chain through config_in/config_out inside the CGRA array.

Parameters:
WIDTH, 32, datapath width; power of two, at least 8.

Ports:
clk  input  1  sole clock; all state updates on rising edge.
reset  input  1  synchronous, active-low; clears all state when sampled low.
config_en  input  1  when high, the configuration chain shifts one bit per clk.
config_in  input  1  serial configuration data in.
config_out  output  1  serial configuration data out (cfg[0]).
in0  input  WIDTH  data input 0.
in1  input  WIDTH  data input 1.
out0  output  WIDTH  tile result (output mux).
out1  output  WIDTH  crossbar output 3 bypass.

Behaviour:
- Config register cfg[12:0]:
  - reset low -> cfg=0 (takes priority over config_en).
  - else config_en=1 -> cfg <= {config_in, cfg[12:1]}.
  - else hold.
  - config_out = cfg[0], combinational.
- Loading word w: drive w[0] first, w[12] last, over 13 enabled cycles; afterwards cfg==w.
- Config fields:
  - opcode = cfg[12:9]
  - omux = cfg[8]
  - s0 = cfg[7:6], s1 = cfg[5:4], s2 = cfg[3:2], s3 = cfg[1:0]
- Fields take effect combinationally. Outputs are undefined-but-deterministic while shifting; no shadow register.
- Crossbar sources: 0=in0, 1=in1, 2=alu_q, 3=constant zero.
  - xo[k] = source[s_k].
  - All combinational; any output may pick any source, including duplicates.
- ALU: A=xo0, B=xo1. alu_q <= f(opcode,A,B) every clk while reset high, including during config shifting. Reset low -> alu_q=0.
- Opcodes (results truncated to WIDTH, wrap-around, no flags):
  - 0 ADD A+B; 1 SUB A-B; 2 MUL low WIDTH bits of A*B.
  - 3 AND; 4 OR; 5 XOR.
  - 6 SHL A<<B[log2 WIDTH-1:0]; 7 LSHR; 8 ASHR (same shift-amount field).
  - 9 EQ (A==B ? 1 : 0); 10 LT signed; 11 LT unsigned (compare results zero-extended).
  - 12 pass A; 13 pass B.
  - 14 MIN signed; 15 NOT A.
- Output mux: out0 = omux ? xo2 : alu_q. out1 = xo3.
- Latency:
  - ALU path: 1 cycle from in0/in1 to out0.
  - Bypass path (omux=1 or out1): 0 cycles, combinational.
- Feedback through source 2 forms an accumulator with no combinational loop; alu_q is the only data register.
- Reset state: cfg=0, so opcode ADD, omux 0, all selects = in0.
  - out0 = 0.
  - out1 = in0 (combinational).
  - config_out = 0.
- Reset asserted mid-operation or mid-shift clears cfg and alu_q on that edge. A partially shifted word is discarded and must be reloaded in full.
- Simultaneous config_en=1 and ALU operation: the ALU computes with the pre-edge cfg; the shift and the alu_q update occur on the same edge.

Test Plan:
1. Reset low 2 cycles, in0=0x11 -> out0=0, out1=0x11, config_out=0. Then 13 shifts of w=0 -> cfg stays 0.
2. Load opcode 0, omux 0, s0=0, s1=1, s2=0, s3=3; in0=5, in1=7 -> out0=12 one cycle later, out1=0. Opcode 1 with in0=3, in1=5 -> out0=0xFFFFFFFE.
3. Accumulate: opcode 0, s0=2, s1=0, in0=1, starting from alu_q=0 -> out0=1,2,3,4 on successive cycles. Reset low mid-count -> out0=0 next cycle.
4. Opcode sweep with A=0x80000001, B=4 across all 16 ops:
   - SHL -> 0x00000010; LSHR -> 0x08000000; ASHR -> 0xF8000000.
   - LT signed -> 1; LT unsigned -> 0; MIN -> 0x80000001; NOT -> 0x7FFFFFFE.
5. Bypass: omux=1, s2=1, in1=0xDEADBEEF -> out0=0xDEADBEEF in the same cycle as in1 is applied.
6. Chain: shift 0x1ABC (LSB first) with config_en=1, then shift 13 zeros -> config_out replays bits 0..12 of 0x1ABC in order. config_en=0 -> cfg and config_out hold.
